// File: rtl/motor_speed_ctrl.sv
// Front-panel fan/motor controller: button pulses select a speed level 0-4,
// which drives a period-aligned PWM output and an optional auto-off countdown.
module motor_speed_ctrl #(
  parameter int unsigned TICK_DIV   = 100_000_000,
  parameter int unsigned PWM_PERIOD = 100
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_btn_up,
  input  logic       i_btn_down,
  input  logic       i_btn_off,
  input  logic       i_btn_timer,
  output logic [2:0] o_led_state,
  output logic       o_pwm,
  output logic [3:0] o_timer_remain,
  output logic       o_auto_off
);

  localparam int unsigned CW = $clog2(PWM_PERIOD + 1);
  localparam int unsigned PW = $clog2(TICK_DIV);

  localparam logic [2:0] S_L0 = 3'd0;
  localparam logic [2:0] S_L1 = 3'd1;
  localparam logic [2:0] S_L2 = 3'd2;
  localparam logic [2:0] S_L3 = 3'd3;
  localparam logic [2:0] S_L4 = 3'd4;

  localparam logic [CW-1:0] PWM_LAST   = CW'(PWM_PERIOD - 1);
  localparam logic [CW-1:0] QUARTER    = CW'(PWM_PERIOD / 4);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [2:0]    level, level_nxt;
  logic [3:0]    timer, timer_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic          auto_nxt;
  logic          tick, expire;
  logic [CW-1:0] pwm_cnt, pwm_cnt_nxt;
  logic [CW-1:0] duty, duty_nxt;
  logic [CW-1:0] target;

  // Auto-off setting sequence 0 -> 5 -> 10 -> 15 -> 0; a partly elapsed
  // countdown advances to the next setting above it.
  function automatic logic [3:0] next_setting(input logic [3:0] t);
    if (t == 4'd0)       return 4'd5;
    else if (t <= 4'd5)  return 4'd10;
    else if (t <= 4'd10) return 4'd15;
    else                 return 4'd0;
  endfunction

  assign tick   = (timer != 4'd0) && (presc == PRESC_LAST);
  assign expire = tick && (timer == 4'd1);

  always_comb begin
    level_nxt = level;
    timer_nxt = timer;
    presc_nxt = '0;
    auto_nxt  = 1'b0;

    if (timer != 4'd0) begin
      if (tick) begin
        if (timer != 4'd1) timer_nxt = timer - 4'd1;
      end else begin
        presc_nxt = presc + PW'(1);
      end
    end

    // Buttons override an expiring tick: the expiry is simply not applied.
    if (i_btn_off) begin
      level_nxt = S_L0;
      timer_nxt = 4'd0;
      presc_nxt = '0;
    end else if (i_btn_up) begin
      if (level != S_L4) level_nxt = level + 3'd1;
    end else if (i_btn_down) begin
      if (level != S_L0) level_nxt = level - 3'd1;
      if (level == S_L1) begin
        timer_nxt = 4'd0;
        presc_nxt = '0;
      end
    end else if (i_btn_timer && (level != S_L0)) begin
      timer_nxt = next_setting(timer);
      presc_nxt = '0;
    end else if (expire) begin
      level_nxt = S_L0;
      timer_nxt = 4'd0;
      auto_nxt  = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      level      <= S_L0;
      timer      <= 4'd0;
      presc      <= '0;
      o_auto_off <= 1'b0;
    end else begin
      level      <= level_nxt;
      timer      <= timer_nxt;
      presc      <= presc_nxt;
      o_auto_off <= auto_nxt;
    end
  end

  assign o_led_state    = level;
  assign o_timer_remain = timer;

  assign target = CW'(level) * QUARTER;

  always_comb begin
    pwm_cnt_nxt = (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + CW'(1);
    duty_nxt    = (pwm_cnt == PWM_LAST) ? target : duty;
  end

  // PWM is compared against the next counter/duty so the registered output
  // lines up with the counter value, leaving no low cycle at 100 % duty.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pwm_cnt <= '0;
      duty    <= '0;
      o_pwm   <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt_nxt;
      duty    <= duty_nxt;
      o_pwm   <= (pwm_cnt_nxt < duty_nxt);
    end
  end

endmodule

// File: tb/tb_motor_speed_ctrl.sv
// Randomized and directed bench for motor_speed_ctrl against a cycle-level
// behavioural model built from the speed/timer/PWM rules.
module tb_motor_speed_ctrl;

  localparam int TD = 10;
  localparam int PP = 8;

  logic       i_clk = 1'b0;
  logic       i_reset_n = 1'b0;
  logic       i_btn_up = 1'b0;
  logic       i_btn_down = 1'b0;
  logic       i_btn_off = 1'b0;
  logic       i_btn_timer = 1'b0;
  logic [2:0] o_led_state;
  logic       o_pwm;
  logic [3:0] o_timer_remain;
  logic       o_auto_off;

  motor_speed_ctrl #(.TICK_DIV(TD), .PWM_PERIOD(PP)) dut (
    .i_clk          (i_clk),
    .i_reset_n      (i_reset_n),
    .i_btn_up       (i_btn_up),
    .i_btn_down     (i_btn_down),
    .i_btn_off      (i_btn_off),
    .i_btn_timer    (i_btn_timer),
    .o_led_state    (o_led_state),
    .o_pwm          (o_pwm),
    .o_timer_remain (o_timer_remain),
    .o_auto_off     (o_auto_off)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int m_level, m_timer, m_elapsed, m_cyc, m_duty, m_pwm, m_auto;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int next_setting(input int t);
    if (t == 0)       return 5;
    else if (t <= 5)  return 10;
    else if (t <= 10) return 15;
    else              return 0;
  endfunction

  task automatic model_reset();
    m_level = 0; m_timer = 0; m_elapsed = 0; m_cyc = 0;
    m_duty = 0; m_pwm = 0; m_auto = 0;
  endtask

  // One clock edge of the specified behaviour, with the buttons seen at that edge.
  task automatic model_step(input bit u, input bit d, input bit o, input bit t);
    int lvl, tmr, el, aut;
    bit second, expiring;
    lvl = m_level; tmr = m_timer; aut = 0;
    second   = (m_timer != 0) && (m_elapsed + 1 == TD);
    expiring = second && (m_timer == 1);
    el = (m_timer == 0 || second) ? 0 : m_elapsed + 1;
    if (second && m_timer > 1) tmr = m_timer - 1;
    if (o) begin
      lvl = 0; tmr = 0; el = 0;
    end else if (u) begin
      lvl = (m_level < 4) ? m_level + 1 : 4;
    end else if (d) begin
      lvl = (m_level > 0) ? m_level - 1 : 0;
      if (lvl == 0) begin tmr = 0; el = 0; end
    end else if (t && m_level != 0) begin
      tmr = next_setting(m_timer); el = 0;
    end else if (expiring) begin
      lvl = 0; tmr = 0; aut = 1;
    end
    m_cyc++;
    if (m_cyc % PP == 0) m_duty = m_level * (PP / 4);
    m_pwm = ((m_cyc % PP) < m_duty) ? 1 : 0;
    m_level = lvl; m_timer = tmr; m_elapsed = el; m_auto = aut;
  endtask

  task automatic compare_all();
    check("led_state",    int'(o_led_state),    m_level);
    check("pwm",          int'(o_pwm),          m_pwm);
    check("timer_remain", int'(o_timer_remain), m_timer);
    check("auto_off",     int'(o_auto_off),     m_auto);
  endtask

  task automatic step(input bit u, input bit d, input bit o, input bit t);
    i_btn_up = u; i_btn_down = d; i_btn_off = o; i_btn_timer = t;
    @(posedge i_clk);
    model_step(u, d, o, t);
    #1;
    i_btn_up = 0; i_btn_down = 0; i_btn_off = 0; i_btn_timer = 0;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  task automatic align_last_phase();
    for (int i = 0; i < PP && (m_cyc % PP) != PP - 1; i++) step(0, 0, 0, 0);
  endtask

  initial begin
    int hi, pulses, at;
    model_reset();
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_led",   int'(o_led_state),    0);
    check("rst_pwm",   int'(o_pwm),          0);
    check("rst_timer", int'(o_timer_remain), 0);
    check("rst_auto",  int'(o_auto_off),     0);
    #3 i_reset_n = 1'b1;

    // Five up presses: saturate at level 4
    for (int k = 1; k <= 5; k++) begin
      step(1, 0, 0, 0);
      check("up_level", int'(o_led_state), (k > 4) ? 4 : k);
    end
    idle(2 * PP);
    align_last_phase();
    hi = 0;
    for (int i = 0; i < PP; i++) begin step(0, 0, 0, 0); hi += int'(o_pwm); end
    check("l4_full_high", hi, PP);

    // Level 2 steady state, then up mid-period
    step(0, 0, 1, 0); step(1, 0, 0, 0); step(1, 0, 0, 0);
    idle(2 * PP);
    align_last_phase();
    hi = 0;
    for (int i = 0; i < PP; i++) begin step(0, 0, 0, 0); hi += int'(o_pwm); end
    check("l2_high", hi, 4);
    hi = 0;
    for (int i = 0; i < PP; i++) begin step(i == 3, 0, 0, 0); hi += int'(o_pwm); end
    check("l2_up_same_period", hi, 4);
    hi = 0;
    for (int i = 0; i < PP; i++) begin step(0, 0, 0, 0); hi += int'(o_pwm); end
    check("l3_next_period", hi, 6);

    // Auto-off countdown from 10 seconds at level 1
    step(0, 0, 1, 0); step(1, 0, 0, 0);
    step(0, 0, 0, 1); check("timer_5", int'(o_timer_remain), 5);
    step(0, 0, 0, 1); check("timer_10", int'(o_timer_remain), 10);
    pulses = 0; at = -1;
    for (int i = 1; i <= 120; i++) begin
      step(0, 0, 0, 0);
      if (o_auto_off) begin
        pulses++; at = i;
        check("expire_led", int'(o_led_state), 0);
        check("expire_timer", int'(o_timer_remain), 0);
      end
    end
    check("auto_off_pulses", pulses, 1);
    check("auto_off_cycle", at, 100);
    align_last_phase();
    hi = 0;
    for (int i = 0; i < PP; i++) begin step(0, 0, 0, 0); hi += int'(o_pwm); end
    check("off_pwm_low", hi, 0);

    // Timer ignored at level 0; full cycle at level 3
    step(0, 0, 0, 1); check("l0_timer_ignored", int'(o_timer_remain), 0);
    step(1, 0, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0);
    step(0, 0, 0, 1); check("cyc_5", int'(o_timer_remain), 5);
    step(0, 0, 0, 1); check("cyc_10", int'(o_timer_remain), 10);
    step(0, 0, 0, 1); check("cyc_15", int'(o_timer_remain), 15);
    step(0, 0, 0, 1); check("cyc_0", int'(o_timer_remain), 0);

    // Simultaneous pulses
    step(0, 0, 0, 1);
    step(1, 1, 1, 0);
    check("prio_off_level", int'(o_led_state), 0);
    check("prio_off_timer", int'(o_timer_remain), 0);
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    check("prio_up_level", int'(o_led_state), 3);

    // Asynchronous reset mid-countdown and mid-period at level 4
    step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    idle(2 * PP + 7);
    for (int i = 0; i < PP && (m_cyc % PP) != 3; i++) step(0, 0, 0, 0);
    check("pre_rst_pwm", int'(o_pwm), 1);
    #2 i_reset_n = 1'b0;
    #1;
    check("arst_led",   int'(o_led_state),    0);
    check("arst_pwm",   int'(o_pwm),          0);
    check("arst_timer", int'(o_timer_remain), 0);
    check("arst_auto",  int'(o_auto_off),     0);
    model_reset();
    repeat (2) @(posedge i_clk);
    #3 i_reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      step(i >= 2 && i < 6, 0, 0, 0);
      pulses += int'(o_auto_off);
    end
    check("post_rst_no_auto", pulses, 0);

    // Randomized button traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 59) == 0, $urandom_range(0, 7) == 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
